data_mem_router: RTL and testbench
==================================

// Module: data_mem_router
// PURPOSE
//  Parametrised data-memory front end. One owner (core or IO loader, chosen by core_active) issues
//  word requests with byte enables. Low addresses go to an on-chip BRAM; higher addresses go to
//  the external DRAM controller over a valid/ready handshake with a timeout.
//  Out-of-range addresses are flagged. Sits between the MEM stage / IO loader and BRAM + DRAM ctrl.
// PARAMETERS
//  LOCAL_AW     12     local BRAM word-address width; local region = [0, 4*2^LOCAL_AW) bytes
//  EXT_AW       27     external byte-address width; valid ext region = [4*2^LOCAL_AW, 2^EXT_AW)
//  EXT_TIMEOUT  1024   max cycles ext_valid may wait for ext_ready (>=2)
// PORTS
//  clk          in   1      clock
//  rstn         in   1      synchronous active-low reset
//  core_active  in   1      1: core owns the port, 0: IO owns it (sampled only in IDLE)
//  core_req     in   1      core request; held with fields stable until core_done
//  core_we      in   1      1 write / 0 read
//  core_be      in   4      write byte enables (ignored on read)
//  core_addr    in   32     byte address; [1:0] ignored
//  core_wdata   in   32     write data
//  core_rdata   out  32     read data; valid when core_done, held until next core_done
//  core_done    out  1      1-cycle completion pulse
//  io_req/io_we/io_be/io_addr/io_wdata/io_rdata/io_done   same as core_*, IO side
//  ext_valid    out  1      external request valid
//  ext_rw       out  1      1 write / 0 read
//  ext_addr     out  EXT_AW byte address, word aligned
//  ext_be       out  4      byte enables
//  ext_wdata    out  32     write data
//  ext_ready    in   1      external completion; ext_rdata valid in the same cycle
//  ext_rdata    in   32     external read data
//  err_oob      out  1      sticky: access at or above 2^EXT_AW; cleared by reset only
//  err_timeout  out  1      sticky: EXT_TIMEOUT expired; cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (rdata, done, ext_*, err_*); timeout counter 0.
//  Reset mid-transaction aborts the transaction. ext_valid is 0 after that edge and ext_ready is ignored.
//  Owner is latched at acceptance. Toggling core_active while busy has no effect until IDLE.
//  The non-owner's req is ignored; its done stays 0 and its rdata holds its last value.
//  FSM: IDLE -> {LWR, LRD1, EXT, ERR} on the accept edge N (state IDLE && owner req=1).
//   LWR : BRAM written with byte enables at edge N; done=1 in cycle N+1 -> IDLE.
//   LRD1: BRAM read issued at edge N -> LRD2 -> rdata latched, done=1 in cycle N+2 -> IDLE.
//   EXT : ext_valid=1 from cycle N+1, ext_* fields registered stable. On the ext_ready edge:
//         capture ext_rdata (reads), drop ext_valid, done=1 next cycle -> IDLE.
//         Counter increments each cycle ext_valid=1 && !ext_ready. At EXT_TIMEOUT: drop ext_valid,
//         set err_timeout, rdata=32'hDEADBEEF (reads), done=1 -> IDLE.
//   ERR : addr >= 2^EXT_AW. No memory access, err_oob set, rdata=0, done=1 next cycle -> IDLE.
//  done is 1 cycle. The requester must drop req in the done cycle or it is re-accepted next edge.
//  ext_ready while ext_valid=0 is ignored.
//  ext_ready in the same cycle the timeout expires: ready wins, no error.
//  Region decode is combinational from the owner addr. Only the accept edge matters.
//  Byte-enable write: byte i written iff be[i]. be=4'b0000 still completes with done.
//  Back-to-back throughput: at most 1 request per 2 cycles local write, 3 cycles local read.
// STRUCTURE
//  Include data_mem_defs.vh (shared): state encodings, REGION_LOCAL/EXT/OOB codes,
//  TIMEOUT_RDATA=32'hDEADBEEF.
//  Sub-module local_bram: inferred single-port 2^LOCAL_AW x 32 RAM, 4 byte write enables,
//  1-cycle registered read. Replaces the vendor IP so depth and byte enables are parametrisable.
//  Top module holds owner mux, decode, FSM, ext handshake regs, timeout counter ($clog2(EXT_TIMEOUT+1)).
// TESTING
//  1 core write 0x0000_0010 data 0xA5A5_1234 be=1111, then read it -> done at N+1 / N+2,
//    rdata 0xA5A5_1234.
//  2 partial write be=0010 data 0xFFFF_FFFF on that word, read -> 0xA5A5_FF34.
//  3 core read 0x0001_0000 with ext_ready after 5 cycles, ext_rdata 0x1357_9BDF ->
//    ext_addr=0x10000, ext_rw=0, done 1 cycle after ready, rdata 0x1357_9BDF.
//  4 ext read, ext_ready never asserted (EXT_TIMEOUT=8) -> ext_valid drops after 8 cycles,
//    rdata 0xDEADBEEF, err_timeout=1.
//  5 core read 0x0800_0000 (EXT_AW=27) -> no ext_valid, err_oob=1, rdata 0, done 1 cycle later.
//  6 core_active 1->0 mid ext access, then rstn=0 mid ext access -> owner unchanged until IDLE;
//    after reset all outputs 0, ext_valid 0.

Source files
------------

// File: rtl/data_mem_router_pkg.sv
// Shared types and constants for the data-memory router: FSM states, region codes, request payload.
package data_mem_router_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LWR,
    S_LRD1,
    S_LRD2,
    S_EXT,
    S_FIN,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    REGION_LOCAL,
    REGION_EXT,
    REGION_OOB
  } region_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_router_local_bram.sv
// Inferred single-port word RAM with per-byte write enables and a registered read port.
module data_mem_router_local_bram
  import data_mem_router_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic              clk,
  input  logic [AW-1:0]     i_addr,
  input  logic [BE_W-1:0]   i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read returns the pre-write contents when the same word is written in that cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_mem_router.sv
// Data-memory front end: owner mux, region decode, local BRAM access, external handshake with timeout.
module data_mem_router
  import data_mem_router_pkg::*;
#(
  parameter int unsigned LOCAL_AW    = 12,
  parameter int unsigned EXT_AW      = 27,
  parameter int unsigned EXT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_core_active,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [BE_W-1:0]   i_core_be,
  input  logic [DATA_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_done,
  input  logic              i_io_req,
  input  logic              i_io_we,
  input  logic [BE_W-1:0]   i_io_be,
  input  logic [DATA_W-1:0] i_io_addr,
  input  logic [DATA_W-1:0] i_io_wdata,
  output logic [DATA_W-1:0] o_io_rdata,
  output logic              o_io_done,
  output logic              o_ext_valid,
  output logic              o_ext_rw,
  output logic [EXT_AW-1:0] o_ext_addr,
  output logic [BE_W-1:0]   o_ext_be,
  output logic [DATA_W-1:0] o_ext_wdata,
  input  logic              i_ext_ready,
  input  logic [DATA_W-1:0] i_ext_rdata,
  output logic              o_err_oob,
  output logic              o_err_timeout
);

  localparam int unsigned CNT_W    = $clog2(EXT_TIMEOUT + 1);
  localparam int unsigned LOCAL_HI = LOCAL_AW + 2;

  mem_req_t          w_req;
  logic              w_req_v;
  region_t           w_region;
  logic              w_accept;
  logic [BE_W-1:0]   w_bram_we;
  logic [DATA_W-1:0] w_bram_rdata;
  logic              w_unused_addr_lo;

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_we, w_we_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_done_nxt;
  logic              w_rd_load;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_ext_load;
  logic              w_ext_valid_nxt;
  logic              w_err_oob_nxt;
  logic              w_err_to_nxt;

  // Owner mux follows core_active live; the owner is only latched at acceptance.
  always_comb begin
    if (i_core_active) begin
      w_req   = {i_core_we, i_core_be, i_core_addr, i_core_wdata};
      w_req_v = i_core_req;
    end else begin
      w_req   = {i_io_we, i_io_be, i_io_addr, i_io_wdata};
      w_req_v = i_io_req;
    end
  end

  assign w_unused_addr_lo = ^w_req.addr[1:0];

  always_comb begin
    w_region = REGION_LOCAL;
    if (|w_req.addr[DATA_W-1:EXT_AW])        w_region = REGION_OOB;
    else if (|w_req.addr[EXT_AW-1:LOCAL_HI]) w_region = REGION_EXT;
  end

  assign w_accept   = (r_state == S_IDLE) && w_req_v;
  assign w_ext_load = w_accept && (w_region == REGION_EXT);
  assign w_bram_we  = (w_accept && (w_region == REGION_LOCAL) && w_req.we) ? w_req.be : '0;

  data_mem_router_local_bram #(
    .AW (LOCAL_AW)
  ) u_bram (
    .clk     (clk),
    .i_addr  (w_req.addr[LOCAL_HI-1:2]),
    .i_we    (w_bram_we),
    .i_wdata (w_req.wdata),
    .o_rdata (w_bram_rdata)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_we_nxt        = r_we;
    w_cnt_nxt       = r_cnt;
    w_done_nxt      = 1'b0;
    w_rd_load       = 1'b0;
    w_rd_val        = '0;
    w_ext_valid_nxt = o_ext_valid;
    w_err_oob_nxt   = o_err_oob;
    w_err_to_nxt    = o_err_timeout;
    case (r_state)
      S_IDLE: begin
        if (w_req_v) begin
          w_owner_nxt = i_core_active;
          w_we_nxt    = w_req.we;
          w_cnt_nxt   = '0;
          case (w_region)
            REGION_LOCAL: begin
              w_state_nxt = w_req.we ? S_LWR : S_LRD1;
              w_done_nxt  = w_req.we;
            end
            REGION_EXT: begin
              w_state_nxt     = S_EXT;
              w_ext_valid_nxt = 1'b1;
            end
            default: begin
              w_state_nxt   = S_ERR;
              w_done_nxt    = 1'b1;
              w_rd_load     = 1'b1;
              w_err_oob_nxt = 1'b1;
            end
          endcase
        end
      end
      S_LRD1: begin
        w_state_nxt = S_LRD2;
        w_done_nxt  = 1'b1;
        w_rd_load   = 1'b1;
        w_rd_val    = w_bram_rdata;
      end
      // A ready arriving in the expiry cycle still completes normally.
      S_EXT: begin
        if (i_ext_ready) begin
          w_state_nxt     = S_FIN;
          w_ext_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_rd_load       = ~r_we;
          w_rd_val        = i_ext_rdata;
        end else if (r_cnt == CNT_W'(EXT_TIMEOUT - 1)) begin
          w_state_nxt     = S_FIN;
          w_ext_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_rd_load       = ~r_we;
          w_rd_val        = TIMEOUT_RDATA;
          w_err_to_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      o_core_rdata  <= '0;
      o_core_done   <= 1'b0;
      o_io_rdata    <= '0;
      o_io_done     <= 1'b0;
      o_ext_valid   <= 1'b0;
      o_ext_rw      <= 1'b0;
      o_ext_addr    <= '0;
      o_ext_be      <= '0;
      o_ext_wdata   <= '0;
      o_err_oob     <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_we          <= w_we_nxt;
      r_cnt         <= w_cnt_nxt;
      o_core_done   <= w_done_nxt & w_owner_nxt;
      o_io_done     <= w_done_nxt & ~w_owner_nxt;
      o_ext_valid   <= w_ext_valid_nxt;
      o_err_oob     <= w_err_oob_nxt;
      o_err_timeout <= w_err_to_nxt;
      if (w_rd_load && w_owner_nxt)  o_core_rdata <= w_rd_val;
      if (w_rd_load && !w_owner_nxt) o_io_rdata   <= w_rd_val;
      if (w_ext_load) begin
        o_ext_rw    <= w_req.we;
        o_ext_addr  <= {w_req.addr[EXT_AW-1:2], 2'b00};
        o_ext_be    <= w_req.be;
        o_ext_wdata <= w_req.wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_router.sv
// Randomised scoreboard bench for data_mem_router; the bench also plays the external DRAM.
module tb_data_mem_router;

  localparam int unsigned LAW = 6;
  localparam int unsigned EAW = 27;
  localparam int          TO  = 8;
  localparam logic [31:0] LOCAL_TOP = 32'h0000_0100;
  localparam logic [31:0] OOB_BASE  = 32'h0800_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_core_active = 1'b1, i_core_req = 1'b0, i_core_we = 1'b0;
  logic [3:0] i_core_be = '0;
  logic [31:0] i_core_addr = '0, i_core_wdata = '0;
  logic i_io_req = 1'b0, i_io_we = 1'b0;
  logic [3:0] i_io_be = '0;
  logic [31:0] i_io_addr = '0, i_io_wdata = '0;
  logic i_ext_ready = 1'b0;
  logic [31:0] i_ext_rdata = '0;
  logic [31:0] o_core_rdata, o_io_rdata, o_ext_wdata;
  logic o_core_done, o_io_done, o_ext_valid, o_ext_rw, o_err_oob, o_err_timeout;
  logic [EAW-1:0] o_ext_addr;
  logic [3:0] o_ext_be;

  data_mem_router #(.LOCAL_AW(LAW), .EXT_AW(EAW), .EXT_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .i_core_active(i_core_active),
    .i_core_req(i_core_req), .i_core_we(i_core_we), .i_core_be(i_core_be),
    .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
    .o_core_rdata(o_core_rdata), .o_core_done(o_core_done),
    .i_io_req(i_io_req), .i_io_we(i_io_we), .i_io_be(i_io_be),
    .i_io_addr(i_io_addr), .i_io_wdata(i_io_wdata),
    .o_io_rdata(o_io_rdata), .o_io_done(o_io_done),
    .o_ext_valid(o_ext_valid), .o_ext_rw(o_ext_rw), .o_ext_addr(o_ext_addr),
    .o_ext_be(o_ext_be), .o_ext_wdata(o_ext_wdata),
    .i_ext_ready(i_ext_ready), .i_ext_rdata(i_ext_rdata),
    .o_err_oob(o_err_oob), .o_err_timeout(o_err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          owner;
    logic [31:0] rdata;
    logic [31:0] other;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  logic [31:0] lmem [64];
  logic [31:0] emem [logic [31:0]];
  logic [31:0] m_rd [2];
  bit m_oob = 1'b0;
  bit m_to = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    if (emem.exists(a)) return emem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected completion.
  always @(negedge clk) begin
    if (rstn && (o_core_done || o_io_done)) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {62'd0, o_core_done, o_io_done}, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("done_owner", {62'd0, o_core_done, o_io_done}, mon_e.owner ? 64'd2 : 64'd1);
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("rdata", mon_e.owner ? o_core_rdata : o_io_rdata, mon_e.rdata);
        chk("other_rdata", mon_e.owner ? o_io_rdata : o_core_rdata, mon_e.other);
      end
    end
  end

  task automatic txn(input bit own, input bit we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, input int d, input bit tog);
    exp_t e;
    int a, k, nv;
    bit seen;
    logic [31:0] wa, xv;
    wa = {addr[31:2], 2'b00};
    xv = ext_rd(wa);
    k = 0; nv = 0; seen = 1'b0;
    @(posedge clk); #1;
    i_core_active = own;
    i_ext_ready = 1'($urandom);
    if (own) begin
      i_core_req = 1'b1; i_core_we = we; i_core_be = be; i_core_addr = addr; i_core_wdata = wd;
      i_io_req = 1'($urandom); i_io_we = 1'($urandom); i_io_addr = 32'($urandom_range(0, 255));
      i_io_be = 4'($urandom); i_io_wdata = $urandom;
    end else begin
      i_io_req = 1'b1; i_io_we = we; i_io_be = be; i_io_addr = addr; i_io_wdata = wd;
      i_core_req = 1'($urandom); i_core_we = 1'($urandom); i_core_addr = 32'($urandom_range(0, 255));
      i_core_be = 4'($urandom); i_core_wdata = $urandom;
    end
    @(posedge clk); #1;
    a = cyc;
    i_ext_ready = 1'b0;
    e.owner = own;
    if (wa >= OOB_BASE) begin
      m_rd[own] = '0; m_oob = 1'b1; e.cyc = a;
    end else if (wa >= LOCAL_TOP) begin
      nv = (d < TO) ? d + 1 : TO;
      e.cyc = a + nv;
      if (d < TO) begin
        if (we) emem[wa] = merge(xv, wd, be);
        else m_rd[own] = xv;
      end else begin
        m_to = 1'b1;
        if (!we) m_rd[own] = 32'hDEAD_BEEF;
      end
    end else if (we) begin
      lmem[wa[7:2]] = merge(lmem[wa[7:2]], wd, be); e.cyc = a;
    end else begin
      m_rd[own] = lmem[wa[7:2]]; e.cyc = a + 1;
    end
    e.rdata = m_rd[own];
    e.other = m_rd[!own];
    q.push_back(e);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (own ? o_core_done : o_io_done) begin
        seen = 1'b1;
      end else if (o_ext_valid) begin
        if (k == 0) begin
          chk("ext_addr", 64'(o_ext_addr), 64'(wa[EAW-1:0]));
          chk("ext_rw", 64'(o_ext_rw), 64'(we));
          if (we) chk("ext_be_wdata", {28'd0, o_ext_be, o_ext_wdata}, {28'd0, be, wd});
        end
        if (tog && k == 1) begin
          i_core_active = !own;
          if (own) i_io_req = 1'b1; else i_core_req = 1'b1;
        end
        i_ext_ready = (k == d);
        i_ext_rdata = (k == d) ? xv : $urandom;
        k++;
      end
    end
    i_core_req = 1'b0; i_io_req = 1'b0; i_ext_ready = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("ext_valid_cycles", 64'(k), 64'(nv));
    chk("err_oob", 64'(o_err_oob), 64'(m_oob));
    chk("err_timeout", 64'(o_err_timeout), 64'(m_to));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rdata"}, {o_core_rdata, o_io_rdata}, 64'd0);
    chk({nm, "_ctrl"}, {55'd0, o_core_done, o_io_done, o_ext_valid, o_ext_rw, o_ext_be,
                        o_err_oob, o_err_timeout}, 64'd0);
    chk({nm, "_ext"}, {5'd0, o_ext_addr, o_ext_wdata}, 64'd0);
  endtask

  initial begin
    int r;
    logic [31:0] ad;
    m_rd[0] = '0; m_rd[1] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) txn(1'($urandom), 1'b1, 4'hF, 32'(4 * i), $urandom, 0, 1'b0);

    txn(1'b1, 1'b1, 4'hF, 32'h10, 32'hA5A5_1234, 0, 1'b0);
    txn(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0);
    txn(1'b1, 1'b1, 4'b0010, 32'h10, 32'hFFFF_FFFF, 0, 1'b0);
    txn(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0);
    emem[32'h0001_0000] = 32'h1357_9BDF;
    txn(1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0, 5, 1'b0);
    txn(1'b1, 1'b0, 4'hF, 32'h0001_0004, 32'h0, TO, 1'b0);
    txn(1'b1, 1'b0, 4'hF, 32'h0800_0000, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b1, 4'hF, 32'hFC, 32'hCAFE_F00D, 0, 1'b0);
    txn(1'b0, 1'b0, 4'hF, 32'hFF, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 4'hF, 32'h104, 32'h0, TO - 1, 1'b0);
    txn(1'b1, 1'b1, 4'b0000, 32'h14, 32'h1111_2222, 0, 1'b0);
    txn(1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b1, 4'b1001, 32'h07FF_FFFC, 32'h8765_4321, 2, 1'b0);
    txn(1'b0, 1'b0, 4'hF, 32'h07FF_FFFC, 32'h0, 1, 1'b0);
    txn(1'b1, 1'b0, 4'hF, 32'h0001_0008, 32'h0, 4, 1'b1);
    txn(1'b0, 1'b1, 4'hF, 32'hFFFF_FFF0, 32'h0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) ad = 32'(4 * $urandom_range(0, 7));
      else if (r < 9) ad = 32'h0001_0000 + 32'(4 * $urandom_range(0, 7));
      else ad = OOB_BASE + 32'(4 * $urandom_range(0, 1000));
      txn(1'($urandom), 1'($urandom), 4'($urandom), ad, $urandom, $urandom_range(0, 10), 1'b0);
    end

    // Abort an external access with reset while ready is offered.
    @(posedge clk); #1;
    i_core_active = 1'b1; i_core_req = 1'b1; i_core_we = 1'b0; i_core_addr = 32'h0001_000C;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_valid", 64'(o_ext_valid), 64'd1);
    rstn = 1'b0; i_ext_ready = 1'b1; i_ext_rdata = $urandom;
    @(negedge clk);
    chk_all_zero("mid_reset");
    i_core_req = 1'b0; rstn = 1'b1;
    m_rd[0] = '0; m_rd[1] = '0; m_oob = 1'b0; m_to = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 64'(o_ext_valid), 64'd0);
    i_ext_ready = 1'b0;
    txn(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 4'hF, 32'h0001_0000, 32'h0, 3, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
